addsub_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 4-bit `adder_subtractor` datapath between NREQ independent requesters. Each requester issues a registered {a, b, sub} operation over a valid/ready handshake. The block returns the 4-bit result, carry/borrow and a zero flag on a single shared response channel, tagged with the requester ID. It sits between the client-side command sources and the arithmetic datapath, and is the only instantiator of `adder_subtractor` in the arithmetic cluster.

---
 rtl/addsub_pkg.sv | 14 +
 rtl/adder_subtractor.sv | 26 ++
 rtl/addsub_arbiter.sv | 148 ++++++++++++++
 tb/tb_addsub_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared definitions for the arithmetic cluster: datapath width, requester
// limit and the sequencer state encoding used by addsub_arbiter.
package addsub_pkg;

    localparam int ADDSUB_W       = 4;
    localparam int ADDSUB_MAX_REQ = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/adder_subtractor.sv
// Combinational 4-bit adder/subtractor: sub=1 computes a + ~b + 1, so carry
// doubles as the active-low borrow.
module adder_subtractor
    import addsub_pkg::*;
(
    input  logic [ADDSUB_W-1:0] a,
    input  logic [ADDSUB_W-1:0] b,
    input  logic                sub,
    output logic [ADDSUB_W-1:0] sum,
    output logic                carry
);

    logic [ADDSUB_W:0] total;
    logic [ADDSUB_W:0] a_ext;
    logic [ADDSUB_W:0] b_ext;
    logic [ADDSUB_W:0] cin_ext;

    assign a_ext   = {1'b0, a};
    assign b_ext   = {1'b0, b ^ {ADDSUB_W{sub}}};
    assign cin_ext = {{ADDSUB_W{1'b0}}, sub};
    assign total   = a_ext + b_ext + cin_ext;

    assign sum   = total[ADDSUB_W-1:0];
    assign carry = total[ADDSUB_W];

endmodule

// File: rtl/addsub_arbiter.sv
// Round-robin sequencer sharing one adder_subtractor between NREQ requesters;
// one operation in flight at a time, response tagged with the requester ID.
module addsub_arbiter
    import addsub_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [ADDSUB_W*NREQ-1:0] req_a,
    input  logic [ADDSUB_W*NREQ-1:0] req_b,
    input  logic [NREQ-1:0]          req_sub,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [IDW-1:0]           rsp_id,
    output logic [ADDSUB_W-1:0]      rsp_result,
    output logic                     rsp_carry,
    output logic                     rsp_zero,
    output logic                     busy
);

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high; req_ready only rises in IDLE and never depends on
    // rsp_ready, and rsp_* stay frozen while rsp_valid waits for rsp_ready.

    localparam int IDW1 = IDW + 1;

    arb_state_t state;
    arb_state_t state_next;

    logic [IDW-1:0]      rr_ptr;
    logic [IDW-1:0]      rr_ptr_next;
    logic [IDW1-1:0]     ptr_inc;

    logic [ADDSUB_W-1:0] op_a;
    logic [ADDSUB_W-1:0] op_b;
    logic                op_sub;
    logic [IDW-1:0]      op_id;

    logic [ADDSUB_W-1:0] dp_sum;
    logic                dp_carry;

    logic [ADDSUB_W-1:0] a_arr [NREQ];
    logic [ADDSUB_W-1:0] b_arr [NREQ];

    logic                grant_found;
    logic [IDW-1:0]      grant_id;
    logic [IDW1-1:0]     cand;

    logic                accept;
    logic                rsp_done;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            a_arr[i] = req_a[i*ADDSUB_W +: ADDSUB_W];
            b_arr[i] = req_b[i*ADDSUB_W +: ADDSUB_W];
        end
    end

    // Rotate by rr_ptr, take the first set bit, map back to an absolute index.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = {1'b0, rr_ptr} + IDW1'(i);
            if (cand >= IDW1'(NREQ)) begin
                cand = cand - IDW1'(NREQ);
            end
            if (!grant_found && req_valid[cand[IDW-1:0]]) begin
                grant_found = 1'b1;
                grant_id    = cand[IDW-1:0];
            end
        end
    end

    assign accept   = (state == ST_IDLE) && grant_found;
    assign rsp_done = (state == ST_RESP) && rsp_ready;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (grant_found) state_next = ST_CALC;
            ST_CALC: state_next = ST_RESP;
            ST_RESP: if (rsp_ready) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    assign ptr_inc     = {1'b0, op_id} + IDW1'(1);
    assign rr_ptr_next = (ptr_inc == IDW1'(NREQ)) ? '0 : ptr_inc[IDW-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            rr_ptr     <= '0;
            op_a       <= '0;
            op_b       <= '0;
            op_sub     <= 1'b0;
            op_id      <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_carry  <= 1'b0;
            rsp_zero   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state     <= state_next;
            busy      <= (state_next != ST_IDLE);
            rsp_valid <= (state_next == ST_RESP);
            if (accept) begin
                op_a   <= a_arr[grant_id];
                op_b   <= b_arr[grant_id];
                op_sub <= req_sub[grant_id];
                op_id  <= grant_id;
            end
            if (state == ST_CALC) begin
                rsp_result <= dp_sum;
                rsp_carry  <= dp_carry;
                rsp_zero   <= (dp_sum == '0);
                rsp_id     <= op_id;
            end
            // Fairness pointer moves only once the response has been taken.
            if (rsp_done) begin
                rr_ptr <= rr_ptr_next;
            end
        end
    end

    adder_subtractor u_adder_subtractor (
        .a     (op_a),
        .b     (op_b),
        .sub   (op_sub),
        .sum   (dp_sum),
        .carry (dp_carry)
    );

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed bench for addsub_arbiter: hand-computed operations, round-robin
// order, response backpressure and reset during CALC.
module tb_addsub_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [3:0]  req_sub;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [3:0]  rsp_result;
    logic        rsp_carry;
    logic        rsp_zero;
    logic        busy;

    int vec_cnt = 0;
    int err_cnt = 0;

    // Expected response tuple {id, result, carry, zero}.
    logic [7:0] exp_q[$];

    addsub_arbiter #(.NREQ(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_sub    (req_sub),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_carry  (rsp_carry),
        .rsp_zero   (rsp_zero),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_id"}, 32'(rsp_id), 32'd0);
        check({tag, "_rsp_result"}, 32'(rsp_result), 32'd0);
        check({tag, "_rsp_carry"}, 32'(rsp_carry), 32'd0);
        check({tag, "_rsp_zero"}, 32'(rsp_zero), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        rst_n = 1'b1;
    endtask

    task automatic set_req(input int id, input logic [3:0] a, input logic [3:0] b, input logic s);
        req_a[id*4 +: 4] = a;
        req_b[id*4 +: 4] = b;
        req_sub[id]      = s;
        req_valid[id]    = 1'b1;
    endtask

    task automatic push_exp(input logic [1:0] id, input logic [3:0] r, input logic c, input logic z);
        exp_q.push_back({id, r, c, z});
    endtask

    // Returns at the cycle where req_ready is seen; the accept is the next rising edge.
    task automatic wait_grant(input logic [3:0] exp_rdy, input string tag, output int waited);
        int n = 0;
        #1;
        while (req_ready == 4'b0 && n < 12) begin
            @(negedge clk);
            #1;
            n++;
        end
        waited = n;
        if (req_ready == 4'b0) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            check(tag, 32'(req_ready), 32'(exp_rdy));
            check({tag, "_busy"}, 32'(busy), 32'd0);
        end
    endtask

    task automatic wait_rsp(input string tag, input logic [3:0] clr);
        int n;
        logic [7:0] got;
        logic [7:0] exp;
        @(negedge clk);
        req_valid = req_valid & ~clr;
        #1;
        n = 1;
        check({tag, "_calc_ready"}, 32'(req_ready), 32'd0);
        check({tag, "_calc_busy"}, 32'(busy), 32'd1);
        while (!rsp_valid && n < 12) begin
            @(negedge clk);
            #1;
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'd2);
        got = {rsp_id, rsp_result, rsp_carry, rsp_zero};
        if (exp_q.size() == 0) begin
            check({tag, "_unexpected"}, 32'd1, 32'd0);
        end else begin
            exp = exp_q.pop_front();
            check(tag, 32'(got), 32'(exp));
        end
    endtask

    task automatic run_op(input int id, input logic [3:0] a, input logic [3:0] b, input logic s,
                          input logic [3:0] r, input logic c, input logic z, input string tag);
        int w;
        @(negedge clk);
        set_req(id, a, b, s);
        wait_grant(4'(1 << id), {tag, "_grant"}, w);
        push_exp(2'(id), r, c, z);
        wait_rsp(tag, 4'(1 << id));
    endtask

    initial begin
        int w;
        logic [7:0] bp_exp;
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_sub   = '0;
        rsp_ready = 1'b1;

        do_reset("reset");

        run_op(0, 4'd5, 4'd3, 1'b0, 4'd8, 1'b0, 1'b0, "add_5_3");
        run_op(1, 4'd3, 4'd5, 1'b1, 4'hE, 1'b0, 1'b0, "sub_3_5");
        run_op(2, 4'd5, 4'd3, 1'b1, 4'd2, 1'b1, 1'b0, "sub_5_3");
        run_op(3, 4'd7, 4'd7, 1'b1, 4'd0, 1'b1, 1'b1, "sub_7_7");
        run_op(0, 4'd9, 4'd8, 1'b0, 4'd1, 1'b1, 1'b0, "add_9_8");
        run_op(1, 4'hF, 4'd1, 1'b0, 4'd0, 1'b1, 1'b1, "add_f_1");

        do_reset("reset2");
        @(negedge clk);
        set_req(0, 4'd3, 4'd1, 1'b0);
        set_req(1, 4'd7, 4'd1, 1'b0);
        set_req(2, 4'd11, 4'd1, 1'b0);
        set_req(3, 4'd15, 4'd1, 1'b0);
        for (int k = 0; k < 6; k++) begin
            int id;
            id = k % 4;
            wait_grant(4'(1 << id), "rr_grant", w);
            case (id)
                0: push_exp(2'd0, 4'd4, 1'b0, 1'b0);
                1: push_exp(2'd1, 4'd8, 1'b0, 1'b0);
                2: push_exp(2'd2, 4'd12, 1'b0, 1'b0);
                default: push_exp(2'd3, 4'd0, 1'b1, 1'b1);
            endcase
            wait_rsp("rr_rsp", (k == 5) ? 4'hF : 4'h0);
        end

        @(negedge clk);
        rsp_ready = 1'b0;
        set_req(3, 4'd6, 4'd2, 1'b1);
        wait_grant(4'b1000, "bp_grant", w);
        push_exp(2'd3, 4'd4, 1'b1, 1'b0);
        wait_rsp("bp_rsp", 4'b1000);
        bp_exp = {2'd3, 4'd4, 1'b1, 1'b0};
        set_req(0, 4'd2, 4'd2, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            check("bp_hold", 32'({rsp_id, rsp_result, rsp_carry, rsp_zero}), 32'(bp_exp));
            check("bp_hold_valid", 32'(rsp_valid), 32'd1);
            check("bp_hold_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        wait_grant(4'b0001, "bp_next", w);
        check("bp_gap", 32'(w), 32'd0);
        check("bp_idle_valid", 32'(rsp_valid), 32'd0);
        push_exp(2'd0, 4'd4, 1'b0, 1'b0);
        wait_rsp("bp_follow", 4'b0001);

        run_op(1, 4'd1, 4'd1, 1'b1, 4'd0, 1'b1, 1'b1, "sub_1_1");
        @(negedge clk);
        set_req(2, 4'd4, 4'd4, 1'b0);
        wait_grant(4'b0100, "rst_grant", w);
        @(negedge clk);
        req_valid = '0;
        #1;
        check("rst_calc_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_result", 32'(rsp_result), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            check("rst_no_rsp", 32'(rsp_valid), 32'd0);
        end
        set_req(1, 4'd2, 4'd9, 1'b1);
        set_req(2, 4'd4, 4'd4, 1'b0);
        wait_grant(4'b0010, "rst_rr_ptr", w);
        push_exp(2'd1, 4'd9, 1'b0, 1'b0);
        wait_rsp("rst_after", 4'b0110);

        @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
